// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM stage of the 5-stage RISC core:
//   - default datapath / register-index widths
//   - MEM-stage FSM state encoding
//   - MEM/WB pipeline bundle layout (at the default widths)
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RF_AW_DEF  = 5;

  // The FSM has exactly two states: it is either free to accept work
  // or waiting for the data memory to acknowledge an access.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // MEM/WB pipeline register contents at the default widths.
  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
    logic [RF_AW_DEF-1:0]  rd;
    logic                  reg_write;
  } mem_wb_t;

endpackage : mem_stage_pkg

// File: rtl/mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline register. Every clock edge either commits a retiring
// instruction or loads a bubble. A bubble clears valid and reg_write but keeps
// data/rd, so the register only toggles the fields that matter.
// A write to register index 0 is never signalled to the register file.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN adds the misalign flag.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   valid_i         commit this edge (0 = bubble)
//   data_i, rd_i    result and destination index to commit
//   reg_write_i     instruction wants to write rd
//   misalign_i/_o   (MEM_MISALIGN_TRAP_EN only) misaligned-access flag
//   valid_o, data_o, rd_o, reg_write_o   registered MEM/WB contents
// -----------------------------------------------------------------------------
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RF_AW  = RF_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [RF_AW-1:0]  rd_i,
  input  logic              reg_write_i,
`ifdef MEM_MISALIGN_TRAP_EN
  input  logic              misalign_i,
  output logic              misalign_o,
`endif
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [RF_AW-1:0]  rd_o,
  output logic              reg_write_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [RF_AW-1:0]  rd_q;
  logic              reg_write_q;

  // Commit a retirement or load a bubble on every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      data_q      <= {DATA_W{1'b0}};
      rd_q        <= {RF_AW{1'b0}};
      reg_write_q <= 1'b0;
    end else if (valid_i) begin
      valid_q     <= 1'b1;
      data_q      <= data_i;
      rd_q        <= rd_i;
      // x0 is hard-wired to zero; never request a write to it.
      reg_write_q <= reg_write_i & (rd_i != {RF_AW{1'b0}});
    end else begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;

  // The trap flag only accompanies the retirement it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (valid_i) begin
      misalign_q <= misalign_i;
    end else begin
      misalign_q <= 1'b0;
    end
  end

  assign misalign_o = misalign_q;
`endif

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign rd_o        = rd_q;
  assign reg_write_o = reg_write_q;

endmodule : mem_wb_reg

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of the 5-stage RISC core. ALU ops pass straight through to the
// MEM/WB register in one cycle. Loads and stores issue a req/ack data-memory
// access; while it is outstanding the stage stalls upstream. The MEM/WB
// register doubles as a forwarding source.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   - memory ops with a non-word-aligned address issue no request and
//               retire next cycle with wb_misalign=1 and no register write.
//   undefined - low address bits are cleared and the access proceeds.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   ex_valid                 EX holds a real instruction
//   ex_alu_result            ALU result / memory byte address
//   ex_store_data            store data
//   ex_rd, ex_reg_write      destination index and write intent
//   ex_mem_read/_write       load / store (mutually exclusive)
//   stall_o                  upstream must hold EX outputs this cycle
//   dmem_req/_we/_addr/_wdata  memory request, held until ack
//   dmem_rdata, dmem_ack     load data and single-cycle completion pulse
//   wb_valid/_data/_rd/_reg_write  MEM/WB register
//   wb_misalign              (MEM_MISALIGN_TRAP_EN only) misaligned access
//   fwd_valid/_rd/_data      forwarding view of MEM/WB
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RF_AW  = RF_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [RF_AW-1:0]  ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [RF_AW-1:0]  wb_rd,
  output logic              wb_reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              wb_misalign,
`endif
  output logic              fwd_valid,
  output logic [RF_AW-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  // FSM state and the latched request (held stable for the whole access).
  state_e            state_q;
  logic              req_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [RF_AW-1:0]  rd_q;
  logic              rw_q;

  // Next MEM/WB contents.
  logic              wb_valid_d;
  logic [DATA_W-1:0] wb_data_d;
  logic [RF_AW-1:0]  wb_rd_d;
  logic              wb_reg_write_d;

  logic              is_mem_s;
  logic              misalign_s;
  logic              accept_mem_s;

  assign is_mem_s = ex_mem_read | ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  logic wb_misalign_d;
  assign misalign_s = is_mem_s & (ex_alu_result[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // A memory op is only taken from IDLE; in ACCESS the EX inputs are ignored.
  assign accept_mem_s = (state_q == ST_IDLE) & ex_valid & is_mem_s & ~misalign_s;

  // Stall generation and selection of what the MEM/WB register loads next.
  always_comb begin
    stall_o        = 1'b0;
    wb_valid_d     = 1'b0;
    wb_data_d      = ex_alu_result;
    wb_rd_d        = ex_rd;
    wb_reg_write_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    wb_misalign_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (is_mem_s && !misalign_s) begin
            // Access starts next edge; hold EX until the ack cycle.
            stall_o    = 1'b1;
            wb_valid_d = 1'b0;
          end else begin
            // ALU op, or a trapped misaligned memory op (never writes rd).
            stall_o        = 1'b0;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = ex_reg_write & ~is_mem_s;
`ifdef MEM_MISALIGN_TRAP_EN
            wb_misalign_d  = misalign_s;
`endif
          end
        end else begin
          stall_o    = 1'b0;
          wb_valid_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        // Releasing the stall in the ack cycle lets EX advance on the same
        // edge that retires the access, so the held op is not taken twice.
        stall_o        = ~dmem_ack;
        wb_valid_d     = dmem_ack;
        wb_rd_d        = rd_q;
        wb_data_d      = we_q ? addr_q : dmem_rdata;
        wb_reg_write_d = rw_q & ~we_q;
      end
      default: begin
        stall_o    = 1'b0;
        wb_valid_d = 1'b0;
      end
    endcase
  end

  // MEM-stage FSM with the registered data-memory request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {DATA_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rd_q    <= {RF_AW{1'b0}};
      rw_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_mem_s) begin
            state_q <= ST_ACCESS;
            req_q   <= 1'b1;
            we_q    <= ex_mem_write;
            addr_q  <= {ex_alu_result[DATA_W-1:2], 2'b00};
            wdata_q <= ex_store_data;
            rd_q    <= ex_rd;
            rw_q    <= ex_reg_write;
          end else begin
            // A stray ack while idle has no effect.
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end else begin
            state_q <= ST_ACCESS;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .RF_AW  (RF_AW)
  ) u_mem_wb_reg (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (wb_valid_d),
    .data_i      (wb_data_d),
    .rd_i        (wb_rd_d),
    .reg_write_i (wb_reg_write_d),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_i  (wb_misalign_d),
    .misalign_o  (wb_misalign),
`endif
    .valid_o     (wb_valid),
    .data_o      (wb_data),
    .rd_o        (wb_rd),
    .reg_write_o (wb_reg_write)
  );

  // Forwarding is a pure view of the MEM/WB register.
  assign fwd_valid = wb_valid & wb_reg_write;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_data;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. Expected retirements (with the cycle in
// which they must appear) are queued when stimulus is driven and compared when
// wb_valid is seen. Inputs change 1ns after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] ex_store_data;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          stall_o;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_rd;
  logic          wb_reg_write;
`ifdef MEM_MISALIGN_TRAP_EN
  logic          wb_misalign;
`endif
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(DW), .RF_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .stall_o       (stall_o),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
`ifdef MEM_MISALIGN_TRAP_EN
    .wb_misalign   (wb_misalign),
`endif
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mis;
    int            at;
  } exp_t;

  typedef struct {
    logic          v;
    logic [DW-1:0] alu;
    logic [AW-1:0] rd;
    logic          rw;
    logic          exp_rw;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] rd,
                      input logic rw, input logic mis, input int dly);
    exp_t e;
    e.data = d; e.rd = rd; e.rw = rw; e.mis = mis; e.at = cyc_n + dly;
    sb.push_back(e);
  endtask

  // Compare a visible retirement against the head of the scoreboard.
  task automatic mon();
    exp_t e;
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire cycle=%0d data=%h rd=%0d", cyc_n, wb_data, wb_rd);
      end else begin
        e = sb.pop_front();
        chk("retire_cycle", cyc_n, e.at);
        chk("wb_data", wb_data, e.data);
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_reg_write", wb_reg_write, e.rw);
        chk("fwd_valid", fwd_valid, e.rw);
        chk("fwd_rd", fwd_rd, e.rd);
        chk("fwd_data", fwd_data, e.data);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("wb_misalign", wb_misalign, e.mis);
`endif
      end
    end
  endtask

  // One clock: sample at the falling edge, then advance past the rising edge.
  task automatic cyc(input logic s, input logic rq, input logic we,
                     input logic [DW-1:0] a, input logic [DW-1:0] wd, input string nm);
    @(negedge clk);
    mon();
    chk({nm, "_stall"}, stall_o, s);
    chk({nm, "_req"}, dmem_req, rq);
    if (rq) begin
      chk({nm, "_we"}, dmem_we, we);
      chk({nm, "_addr"}, dmem_addr, a);
      chk({nm, "_wdata"}, dmem_wdata, wd);
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                       input logic [AW-1:0] rd, input logic rw, input logic mr, input logic mw);
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd;
    ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
  endtask

  task automatic idle_cyc(input string nm);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, nm);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{v: 1'b1, alu: 32'h0000_1234, rd: 5'd5,  rw: 1'b1, exp_rw: 1'b1};
    tbl[1] = '{v: 1'b1, alu: 32'hFFFF_FFFF, rd: 5'd31, rw: 1'b1, exp_rw: 1'b1};
    tbl[2] = '{v: 1'b1, alu: 32'h0000_0055, rd: 5'd0,  rw: 1'b1, exp_rw: 1'b0};
    tbl[3] = '{v: 1'b0, alu: 32'h0BAD_0BAD, rd: 5'd9,  rw: 1'b1, exp_rw: 1'b0};
    tbl[4] = '{v: 1'b1, alu: 32'h0000_000A, rd: 5'd12, rw: 1'b0, exp_rw: 1'b0};
    tbl[5] = '{v: 1'b1, alu: 32'h8000_0000, rd: 5'd1,  rw: 1'b1, exp_rw: 1'b1};

    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    @(negedge clk);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_reg_write", wb_reg_write, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table of ALU ops / bubbles: one-cycle latency, never a stall.
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].alu, 32'h0, tbl[i].rd, tbl[i].rw, 1'b0, 1'b0);
      if (tbl[i].v) push(tbl[i].alu, tbl[i].rd, tbl[i].exp_rw, 1'b0, 1);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, $sformatf("vec%0d", i));
    end
    idle_cyc("vec_drain");

    // Ack while idle is ignored.
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    idle_cyc("idle_ack");
    dmem_ack = 1'b0;
    idle_cyc("idle_ack_after");

    // Load, ack in the third request cycle.
    drive(1'b1, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    push(32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 4);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "ld_present");
    cyc(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, "ld_wait1");
    cyc(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, "ld_wait2");
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, "ld_ack");
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    idle_cyc("ld_retire");
    idle_cyc("ld_after");

    // Store, immediate ack; latched reg_write must not reach the RF.
    drive(1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 5'd9, 1'b1, 1'b0, 1'b1);
    push(32'h0000_2004, 5'd9, 1'b0, 1'b0, 2);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "st_present");
    dmem_ack = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_2004, 32'hA5A5_A5A5, "st_ack");
    dmem_ack = 1'b0;
    idle_cyc("st_retire");

    // Misaligned load address.
`ifdef MEM_MISALIGN_TRAP_EN
    drive(1'b1, 32'h0000_010B, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
    push(32'h0000_010B, 5'd4, 1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "mis_present");
    idle_cyc("mis_retire");
`else
    drive(1'b1, 32'h0000_010B, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
    push(32'h1357_9BDF, 5'd4, 1'b1, 1'b0, 2);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "mis_present");
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1357_9BDF;
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_0108, 32'h0, "mis_ack");
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    idle_cyc("mis_retire");
`endif

    // Reset in the middle of an access; the late ack must be ignored.
    drive(1'b1, 32'h0000_0300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "rst_ld_present");
    chk("rst_ld_req_up", dmem_req, 1'b1);
    #2;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mid_rst_req", dmem_req, 1'b0);
    chk("mid_rst_wb_valid", wb_valid, 1'b0);
    chk("mid_rst_wb_data", wb_data, 32'h0);
    chk("mid_rst_wb_rd", wb_rd, 5'd0);
    chk("mid_rst_wb_reg_write", wb_reg_write, 1'b0);
    chk("mid_rst_stall", stall_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFEED_FACE;
    idle_cyc("stray_ack");
    dmem_ack = 1'b0;
    idle_cyc("stray_ack_after");
    idle_cyc("stray_ack_after2");

    // Load at 0x10 then an ALU op held behind it by the stall.
    drive(1'b1, 32'h0000_0010, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
    push(32'h1111_2222, 5'd2, 1'b1, 1'b0, 3);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "b2b_present");
    cyc(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "b2b_wait");
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1111_2222;
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, "b2b_ack");
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b1, 32'h0000_0055, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    push(32'h0000_0055, 5'd3, 1'b1, 1'b0, 1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "b2b_alu");
    idle_cyc("b2b_alu_retire");
    idle_cyc("b2b_tail1");
    idle_cyc("b2b_tail2");

    // Every queued retirement must have appeared.
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_stage
